// File: rtl/seq_det_if.sv
// Serial bit stream handshake between a bit source (master) and the detector (slave).
interface seq_det_if;
   logic din;
   logic din_valid;
   logic din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/seq_det_ctrl.sv
// Run controller for programmable serial pattern detection with match counting.
// Optional macro SEQ_DET_NOOVERLAP_EN: non-overlapping detection (history discarded after a match).
module seq_det_ctrl #(
   parameter int unsigned PAT_MAX = 8,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned WIN_W   = 8,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   seq_det_if.slave           bit_if,
   input  logic               start_i,
   input  logic [PAT_MAX-1:0] cfg_pat_i,
   input  logic [LEN_W-1:0]   cfg_len_i,
   input  logic [WIN_W-1:0]   cfg_win_i,
   output logic               busy_o,
   output logic               det_o,
   output logic [CNT_W-1:0]   match_cnt_o,
   output logic               done_o
);

   localparam int unsigned FILL_W = $clog2(PAT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [PAT_MAX-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [PAT_MAX-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [WIN_W-1:0]   bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               det_q, det_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               rdy_q, rdy_d;

   logic [PAT_MAX-1:0] hist_sh;
   logic [PAT_MAX-1:0] mask;
   logic [FILL_W-1:0]  fill_inc;
   logic [LEN_W-1:0]   len_clamp;
   logic               accept;
   logic               hit;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         pat_q    <= '0;
         len_q    <= '0;
         win_q    <= '0;
         hist_q   <= '0;
         fill_q   <= '0;
         bitcnt_q <= '0;
         cnt_q    <= '0;
         det_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         win_q    <= win_d;
         hist_q   <= hist_d;
         fill_q   <= fill_d;
         bitcnt_q <= bitcnt_d;
         cnt_q    <= cnt_d;
         det_q    <= det_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
      end
   end

   // Next-state, match evaluation and registered-output decode
   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      len_d    = len_q;
      win_d    = win_q;
      hist_d   = hist_q;
      fill_d   = fill_q;
      bitcnt_d = bitcnt_q;
      cnt_d    = cnt_q;
      det_d    = 1'b0;

      if (cfg_len_i == '0) begin
         len_clamp = LEN_W'(1);
      end else if (32'(cfg_len_i) > PAT_MAX) begin
         len_clamp = LEN_W'(PAT_MAX);
      end else begin
         len_clamp = cfg_len_i;
      end

      hist_sh  = {hist_q[PAT_MAX-2:0], bit_if.din};
      fill_inc = (fill_q == FILL_W'(PAT_MAX)) ? fill_q : fill_q + 1'b1;
      for (int unsigned i = 0; i < PAT_MAX; i++) begin
         mask[i] = (i < 32'(len_q));
      end
      // Match uses the post-shift history and needs at least len bits seen
      hit    = (((hist_sh ^ pat_q) & mask) == '0) && (32'(fill_inc) >= 32'(len_q));
      accept = rdy_q && bit_if.din_valid;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pat_d    = cfg_pat_i;
               len_d    = len_clamp;
               win_d    = cfg_win_i;
               hist_d   = '0;
               fill_d   = '0;
               bitcnt_d = '0;
               cnt_d    = '0;
               state_d  = (cfg_win_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               hist_d   = hist_sh;
               fill_d   = fill_inc;
               bitcnt_d = bitcnt_q + 1'b1;
               if (hit) begin
                  det_d = 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
`ifdef SEQ_DET_NOOVERLAP_EN
                  fill_d = '0;
`else
                  fill_d = fill_inc;
`endif
               end
               if (WIN_W'(bitcnt_q + 1'b1) == win_q) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
      rdy_d  = (state_d == S_RUN);
   end

   assign bit_if.din_ready = rdy_q;
   assign busy_o           = busy_q;
   assign det_o            = det_q;
   assign match_cnt_o      = cnt_q;
   assign done_o           = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (both overlap modes via SEQ_DET_NOOVERLAP_EN).
module tb_seq_det_ctrl;

`ifdef SEQ_DET_NOOVERLAP_EN
   localparam bit NOOVL = 1'b1;
`else
   localparam bit NOOVL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_i = 1'b0;
   logic [7:0] cfg_pat_i = '0;
   logic [3:0] cfg_len_i = '0;
   logic [7:0] cfg_win_i = '0;
   logic       busy_o, det_o, done_o;
   logic [7:0] match_cnt_o;
   int         total = 0;
   int         bad = 0;

   seq_det_if bif();

   seq_det_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .bit_if      (bif),
      .start_i     (start_i),
      .cfg_pat_i   (cfg_pat_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_win_i   (cfg_win_i),
      .busy_o      (busy_o),
      .det_o       (det_o),
      .match_cnt_o (match_cnt_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] win);
      cfg_pat_i = pat;
      cfg_len_i = len;
      cfg_win_i = win;
      start_i   = 1'b1;
      tick();
      start_i   = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bif.din       = b;
      bif.din_valid = 1'b1;
      tick();
      bif.din_valid = 1'b0;
   endtask

   logic [8:0] s9;

   initial begin
      bif.din       = 1'b0;
      bif.din_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rst_busy", busy_o, 0);
      check("rst_ready", bif.din_ready, 0);
      check("rst_det", det_o, 0);
      check("rst_done", done_o, 0);
      check("rst_cnt", match_cnt_o, 0);

      // Overlap scenario: 1,0,1,0,1 against 101
      do_start(8'h05, 4'd3, 8'd5);
      check("ov_ready", bif.din_ready, 1);
      check("ov_busy", busy_o, 1);
      send_bit(1'b1); check("ov_det1", det_o, 0);
      send_bit(1'b0); check("ov_det2", det_o, 0);
      send_bit(1'b1); check("ov_det3", det_o, 1);
      check("ov_cnt3", match_cnt_o, 1);
      check("ov_done3", done_o, 0);
      send_bit(1'b0); check("ov_det4", det_o, 0);
      send_bit(1'b1); check("ov_det5", det_o, NOOVL ? 0 : 1);
      check("ov_done5", done_o, 1);
      check("ov_ready5", bif.din_ready, 0);
      check("ov_cnt5", match_cnt_o, NOOVL ? 1 : 2);
      tick();
      check("ov_done_end", done_o, 0);
      check("ov_busy_end", busy_o, 0);
      tick(); tick();
      check("ov_cnt_hold", match_cnt_o, NOOVL ? 1 : 2);

      // Backpressure gaps plus an ignored start mid-run: 1,1,0,1 against 101
      do_start(8'h05, 4'd3, 8'd4);
      check("bp_cnt_clr", match_cnt_o, 0);
      send_bit(1'b1); check("bp_det1", det_o, 0);
      cfg_pat_i = 8'hFF; cfg_len_i = 4'd1; cfg_win_i = 8'd1;
      start_i = 1'b1; tick(); start_i = 1'b0;
      check("bp_gap_busy", busy_o, 1);
      check("bp_gap_ready", bif.din_ready, 1);
      check("bp_gap_done", done_o, 0);
      send_bit(1'b1); check("bp_det2", det_o, 0);
      tick();
      send_bit(1'b0); check("bp_det3", det_o, 0);
      check("bp_done3", done_o, 0);
      tick();
      check("bp_idle_done", done_o, 0);
      send_bit(1'b1); check("bp_det4", det_o, 1);
      check("bp_done4", done_o, 1);
      check("bp_cnt4", match_cnt_o, 1);
      tick();

      // Length 0 treated as 1: stream 1,1,0 against bit0=1
      do_start(8'h01, 4'd0, 8'd3);
      send_bit(1'b1); check("l0_det1", det_o, 1);
      send_bit(1'b1); check("l0_det2", det_o, 1);
      send_bit(1'b0); check("l0_det3", det_o, 0);
      check("l0_done", done_o, 1);
      check("l0_cnt", match_cnt_o, 2);
      tick();

      // Length 15 clamps to 8: stream A5 then one extra 0
      do_start(8'hA5, 4'd15, 8'd9);
      s9 = 9'b1_0100_1010;
      for (int i = 8; i >= 0; i--) begin
         send_bit(s9[i]);
         check("l15_det", det_o, (i == 1) ? 1 : 0);
      end
      check("l15_done", done_o, 1);
      check("l15_cnt", match_cnt_o, 1);
      tick();

      // Zero window goes straight to DONE
      do_start(8'h05, 4'd3, 8'd0);
      check("w0_done", done_o, 1);
      check("w0_busy", busy_o, 1);
      check("w0_ready", bif.din_ready, 0);
      check("w0_cnt", match_cnt_o, 0);
      tick();
      check("w0_done_end", done_o, 0);
      check("w0_busy_end", busy_o, 0);

      // Reset mid-run aborts asynchronously
      do_start(8'h05, 4'd3, 8'd5);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("mr_det_pre", det_o, 1);
      rst = 1'b0;
      #1;
      check("mr_det", det_o, 0);
      check("mr_busy", busy_o, 0);
      check("mr_ready", bif.din_ready, 0);
      check("mr_cnt", match_cnt_o, 0);
      check("mr_done", done_o, 0);
      tick();
      check("mr_hold_done", done_o, 0);
      rst = 1'b1;
      tick();
      do_start(8'h01, 4'd1, 8'd1);
      check("mr_restart_ready", bif.din_ready, 1);
      send_bit(1'b1);
      check("mr_restart_det", det_o, 1);
      check("mr_restart_done", done_o, 1);
      check("mr_restart_cnt", match_cnt_o, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
